quad_row_sequencer: RTL and testbench

//   Initiator side of the quad rasterizer. Accepts one quad (4 CCW vertices + colour), walks drawY

---
 rtl/quad_row_sequencer.sv | 146 ++++++++++++++
 tb/tb_quad_row_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_row_sequencer.sv
// Quad row sequencer: walks a quad's Y extent and emits CHUNK-wide masked write beats.
// Optional QUAD_SEQ_SKIP_EMPTY_EN: all-zero chunks are consumed without a beat.
module quad_row_sequencer #(
   parameter int WARP_WIDTH = 240,
   parameter int CHUNK      = 16,
   parameter int SCREEN_H   = 480,
   parameter int COLOR_W    = 12
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   quad_valid,
   output logic                   quad_ready,
   input  logic [3:0][1:0][9:0]   quad_vertices,
   input  logic [COLOR_W-1:0]     quad_color,
   output logic [3:0][1:0][9:0]   rast_vertices,
   output logic [9:0]             rast_drawY,
   input  logic [WARP_WIDTH-1:0]  rast_isInside,
   output logic                   wr_valid,
   input  logic                   wr_ready,
   output logic [9:0]             wr_y,
   output logic [9:0]             wr_x,
   output logic [CHUNK-1:0]       wr_mask,
   output logic [COLOR_W-1:0]     wr_color,
   output logic                   busy,
   output logic                   done
);

   localparam int NCHUNK = WARP_WIDTH / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [9:0]    YLAST = 10'(SCREEN_H - 1);
   localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SAMPLE = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [3:0][1:0][9:0]  vert_q, vert_d;
   logic [COLOR_W-1:0]    color_q, color_d;
   logic [9:0]            y_q, y_d;
   logic [9:0]            ymax_q, ymax_d;
   logic [WARP_WIDTH-1:0] mask_q, mask_d;
   logic [KW-1:0]         k_q, k_d;

   logic [9:0]       in_ymin;
   logic [9:0]       in_ymax;
   logic [CHUNK-1:0] chunk;
   logic             skip;
   logic             advance;

   always_comb begin
      in_ymin = quad_vertices[0][1];
      in_ymax = quad_vertices[0][1];
      for (int i = 1; i < 4; i++) begin
         if (quad_vertices[i][1] < in_ymin) in_ymin = quad_vertices[i][1];
         if (quad_vertices[i][1] > in_ymax) in_ymax = quad_vertices[i][1];
      end
   end

   assign chunk = mask_q[k_q*CHUNK +: CHUNK];

`ifdef QUAD_SEQ_SKIP_EMPTY_EN
   assign skip = (chunk == '0);
`else
   assign skip = 1'b0;
`endif

   assign wr_valid = (state_q == S_EMIT) && !skip;
   assign advance  = (state_q == S_EMIT) && (skip || wr_ready);

   always_comb begin
      state_d = state_q;
      vert_d  = vert_q;
      color_d = color_q;
      y_d     = y_q;
      ymax_d  = ymax_q;
      mask_d  = mask_q;
      k_d     = k_q;
      unique case (state_q)
         S_IDLE: begin
            if (quad_valid) begin
               vert_d  = quad_vertices;
               color_d = quad_color;
               y_d     = in_ymin;
               ymax_d  = (in_ymax > YLAST) ? YLAST : in_ymax;
               state_d = (in_ymin > YLAST) ? S_DONE : S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            mask_d  = rast_isInside;
            k_d     = '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (advance) begin
               if (k_q == KLAST) begin
                  if (y_q == ymax_q) begin
                     state_d = S_DONE;
                  end else begin
                     y_d     = y_q + 10'd1;
                     state_d = S_SAMPLE;
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         vert_q  <= '0;
         color_q <= '0;
         y_q     <= '0;
         ymax_q  <= '0;
         mask_q  <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         vert_q  <= vert_d;
         color_q <= color_d;
         y_q     <= y_d;
         ymax_q  <= ymax_d;
         mask_q  <= mask_d;
         k_q     <= k_d;
      end
   end

   assign quad_ready    = (state_q == S_IDLE);
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign rast_vertices = vert_q;
   assign rast_drawY    = y_q;
   assign wr_y          = y_q;
   assign wr_x          = 10'(k_q * CHUNK);
   assign wr_mask       = chunk;
   assign wr_color      = color_q;

endmodule

// File: tb/tb_quad_row_sequencer.sv
// Directed bench for quad_row_sequencer with a bounding-box rasterizer model.
// Expectations follow QUAD_SEQ_SKIP_EMPTY_EN when it is defined.
module tb_quad_row_sequencer;

   localparam int WW = 240;

   typedef logic [3:0][1:0][9:0] quad_t;

   typedef struct {
      int          cyc;
      logic [9:0]  y;
      logic [9:0]  x;
      logic [15:0] m;
      logic [11:0] c;
   } beat_t;

   typedef struct {
      quad_t       v;
      logic [11:0] c;
      int          nbeats;
      int          lat;
      int          fy;
      int          fx;
      logic [15:0] fm;
      int          ly;
      int          lx;
      logic [15:0] lm;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          quad_valid = 1'b0;
   logic          quad_ready;
   quad_t         quad_vertices = '0;
   logic [11:0]   quad_color = '0;
   quad_t         rast_vertices;
   logic [9:0]    rast_drawY;
   logic [WW-1:0] isin;
   logic          wr_valid;
   logic          wr_ready = 1'b1;
   logic [9:0]    wr_y;
   logic [9:0]    wr_x;
   logic [15:0]   wr_mask;
   logic [11:0]   wr_color;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   quad_row_sequencer dut (
      .Clk           (clk),
      .Reset         (rst),
      .quad_valid    (quad_valid),
      .quad_ready    (quad_ready),
      .quad_vertices (quad_vertices),
      .quad_color    (quad_color),
      .rast_vertices (rast_vertices),
      .rast_drawY    (rast_drawY),
      .rast_isInside (isin),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_y          (wr_y),
      .wr_x          (wr_x),
      .wr_mask       (wr_mask),
      .wr_color      (wr_color),
      .busy          (busy),
      .done          (done)
   );

   function automatic logic in_box(input quad_t v, input int px, input int py);
      int x0, x1, y0, y1;
      x0 = int'(v[0][0]); x1 = x0;
      y0 = int'(v[0][1]); y1 = y0;
      for (int i = 1; i < 4; i++) begin
         if (int'(v[i][0]) < x0) x0 = int'(v[i][0]);
         if (int'(v[i][0]) > x1) x1 = int'(v[i][0]);
         if (int'(v[i][1]) < y0) y0 = int'(v[i][1]);
         if (int'(v[i][1]) > y1) y1 = int'(v[i][1]);
      end
      return (px >= x0) && (px <= x1) && (py >= y0) && (py <= y1);
   endfunction

   always_comb begin
      isin = '0;
      for (int x = 0; x < WW; x++)
         isin[x] = in_box(rast_vertices, x, int'(rast_drawY));
   end

   beat_t beats[$];
   int    dones[$];
   int    accs[$];
   int    ncyc = 0;
   int    bad_ready = 0;

   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (!rst) begin
         if (quad_valid && quad_ready) accs.push_back(ncyc);
         if (wr_valid && wr_ready)
            beats.push_back('{ncyc, wr_y, wr_x, wr_mask, wr_color});
         if (done) dones.push_back(ncyc);
         if (busy && quad_ready) bad_ready <= bad_ready + 1;
      end
   end

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic quad_t mkq(input int x0, y0, x1, y1, x2, y2, x3, y3);
      quad_t q;
      q[0][0] = 10'(x0); q[0][1] = 10'(y0);
      q[1][0] = 10'(x1); q[1][1] = 10'(y1);
      q[2][0] = 10'(x2); q[2][1] = 10'(y2);
      q[3][0] = 10'(x3); q[3][1] = 10'(y3);
      return q;
   endfunction

   function automatic vec_t mkv(input quad_t v, input logic [11:0] c,
                                input int nb, lat, fy, fx, input logic [15:0] fm,
                                input int ly, lx, input logic [15:0] lm);
      vec_t t;
      t.v = v; t.c = c; t.nbeats = nb; t.lat = lat;
      t.fy = fy; t.fx = fx; t.fm = fm;
      t.ly = ly; t.lx = lx; t.lm = lm;
      return t;
   endfunction

   vec_t tbl[6];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input vec_t t);
      int a0, w;
      a0 = accs.size();
      quad_vertices = t.v;
      quad_color    = t.c;
      quad_valid    = 1'b1;
      w = 0;
      while (accs.size() == a0 && w < 100) begin step(); w++; end
      quad_valid = 1'b0;
   endtask

   task automatic wait_dones(input int d0, input int n, input int lim);
      int w;
      w = 0;
      while (dones.size() - d0 < n && w < lim) begin step(); w++; end
   endtask

   task automatic run_vec(input int id);
      vec_t t;
      int a0, d0, b0, nb, bad;
      t  = tbl[id];
      a0 = accs.size(); d0 = dones.size(); b0 = beats.size();
      wr_ready = 1'b1;
      offer(t);
      chk($sformatf("v%0d_accept", id), accs.size() - a0, 1);
      wait_dones(d0, 1, 3000);
      chk($sformatf("v%0d_ready_after", id), quad_ready, 1'b1);
      step();
      chk($sformatf("v%0d_done_count", id), dones.size() - d0, 1);
      if (accs.size() > a0 && dones.size() > d0)
         chk($sformatf("v%0d_done_lat", id), dones[d0] - accs[a0], t.lat);
      nb = beats.size() - b0;
      chk($sformatf("v%0d_beats", id), nb, t.nbeats);
      if (nb > 0 && t.nbeats > 0) begin
         chk($sformatf("v%0d_first", id), {beats[b0].y, beats[b0].x, beats[b0].m},
             {10'(t.fy), 10'(t.fx), t.fm});
         chk($sformatf("v%0d_last", id),
             {beats[b0+nb-1].y, beats[b0+nb-1].x, beats[b0+nb-1].m},
             {10'(t.ly), 10'(t.lx), t.lm});
      end
      bad = 0;
      for (int i = b0; i < b0 + nb; i++) begin
         if (beats[i].c !== t.c) bad++;
         for (int j = 0; j < 16; j++)
            if (beats[i].m[j] !== in_box(t.v, int'(beats[i].x) + j, int'(beats[i].y))) bad++;
      end
      chk($sformatf("v%0d_mask_model", id), bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a0, d0, b0, w, n1, bad;
      logic [48:0] snap;

`ifdef QUAD_SEQ_SKIP_EMPTY_EN
      tbl[0] = mkv(mkq(15,10, 0,10, 0,11, 15,11), 12'hABC, 2, 33, 10, 0, 16'hFFFF, 11, 0, 16'hFFFF);
      tbl[1] = mkv(mkq(0,500, 10,500, 10,500, 0,500), 12'h123, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);
      tbl[2] = mkv(mkq(100,5, 120,5, 120,5, 100,5), 12'h456, 2, 17, 5, 96, 16'hFFF0, 5, 112, 16'h01FF);
      tbl[3] = mkv(mkq(239,600, 230,600, 230,476, 239,476), 12'h789, 4, 65, 476, 224, 16'hFFC0, 479, 224, 16'hFFC0);
      tbl[4] = mkv(mkq(300,20, 310,20, 310,21, 300,21), 12'hF0F, 0, 33, 0, 0, 16'h0, 0, 0, 16'h0);
      tbl[5] = mkv(mkq(0,479, 0,479, 0,479, 0,479), 12'h5A5, 1, 17, 479, 0, 16'h0001, 479, 0, 16'h0001);
`else
      tbl[0] = mkv(mkq(15,10, 0,10, 0,11, 15,11), 12'hABC, 30, 33, 10, 0, 16'hFFFF, 11, 224, 16'h0);
      tbl[1] = mkv(mkq(0,500, 10,500, 10,500, 0,500), 12'h123, 0, 1, 0, 0, 16'h0, 0, 0, 16'h0);
      tbl[2] = mkv(mkq(100,5, 120,5, 120,5, 100,5), 12'h456, 15, 17, 5, 0, 16'h0, 5, 224, 16'h0);
      tbl[3] = mkv(mkq(239,600, 230,600, 230,476, 239,476), 12'h789, 60, 65, 476, 0, 16'h0, 479, 224, 16'hFFC0);
      tbl[4] = mkv(mkq(300,20, 310,20, 310,21, 300,21), 12'hF0F, 30, 33, 20, 0, 16'h0, 21, 224, 16'h0);
      tbl[5] = mkv(mkq(0,479, 0,479, 0,479, 0,479), 12'h5A5, 15, 17, 479, 0, 16'h0001, 479, 224, 16'h0);
`endif

      // Reset state
      repeat (3) step();
      chk("rst_quad_ready", quad_ready, 1'b1);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_drawY", rast_drawY, 10'd0);
      chk("rst_vertices", rast_vertices, 80'd0);
      chk("rst_wr_xy", {wr_x, wr_y}, 20'd0);
      chk("rst_wr_mask", wr_mask, 16'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) run_vec(i);

      // Back-pressure on the first beat
      d0 = dones.size(); b0 = beats.size();
      wr_ready = 1'b0;
      offer(tbl[0]);
      w = 0;
      while (!wr_valid && w < 20) begin step(); w++; end
      chk("stall_valid_seen", wr_valid, 1'b1);
      snap = {wr_valid, wr_y, wr_x, wr_mask, wr_color};
      chk("stall_first_beat", snap, {1'b1, 10'd10, 10'd0, 16'hFFFF, 12'hABC});
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("stall_hold%0d", i), {wr_valid, wr_y, wr_x, wr_mask, wr_color}, snap);
      end
      chk("stall_no_beats", beats.size() - b0, 0);
      wr_ready = 1'b1;
      wait_dones(d0, 1, 3000);
      step();
      chk("stall_done", dones.size() - d0, 1);
      chk("stall_beats", beats.size() - b0, tbl[0].nbeats);

      // Reset while emitting the second row
      d0 = dones.size();
      offer(tbl[0]);
      w = 0;
      while (!(wr_valid && wr_y == 10'd11) && w < 100) begin step(); w++; end
      chk("midrst_row2_seen", {wr_valid, wr_y}, {1'b1, 10'd11});
      rst = 1'b1;
      step();
      chk("midrst_wr_valid", wr_valid, 1'b0);
      chk("midrst_ready", quad_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      rst = 1'b0;
      repeat (4) step();
      chk("midrst_no_done", dones.size() - d0, 0);
      chk("midrst_idle", {busy, quad_ready}, 2'b01);

      // Back-to-back offers with quad_valid held
      a0 = accs.size(); d0 = dones.size(); b0 = beats.size();
      quad_vertices = tbl[0].v;
      quad_color    = tbl[0].c;
      quad_valid    = 1'b1;
      w = 0;
      while (accs.size() - a0 < 1 && w < 100) begin step(); w++; end
      quad_vertices = tbl[2].v;
      quad_color    = tbl[2].c;
      w = 0;
      while (accs.size() - a0 < 2 && w < 500) begin step(); w++; end
      quad_valid = 1'b0;
      chk("b2b_accepts", accs.size() - a0, 2);
      wait_dones(d0, 2, 3000);
      step();
      chk("b2b_dones", dones.size() - d0, 2);
      chk("b2b_beats", beats.size() - b0, tbl[0].nbeats + tbl[2].nbeats);
      if (accs.size() - a0 >= 2 && dones.size() > d0) begin
         chk("b2b_acc_after_done", accs[a0+1], dones[d0] + 1);
         n1 = 0; bad = 0;
         for (int i = b0; i < beats.size(); i++) begin
            if (beats[i].cyc < accs[a0+1]) begin
               n1++;
               if (beats[i].c !== tbl[0].c) bad++;
            end else if (beats[i].y !== 10'd5 || beats[i].c !== tbl[2].c) begin
               bad++;
            end
         end
         chk("b2b_first_quad_beats", n1, tbl[0].nbeats);
         chk("b2b_order", bad, 0);
      end

      chk("ready_low_while_busy", bad_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
